fetch_unit: RTL
===============

// Module: fetch_unit
//
// PURPOSE
// - Instruction fetch stage. Sits between the core's dual-port BRAM (port A, read-only use) and decode.
// - Holds the PC and issues one word read per cycle to the BRAM (1-cycle synchronous read latency).
// - Buffers returned words in a small instruction queue.
// - Presents {instruction, PC} to decode over a valid/ready handshake.
// - Handles PC redirects (branches/jumps) by flushing the queue and squashing in-flight reads.
//
// PARAMETERS
// - DATA_WIDTH  `DATA_WIDTH (32)  instruction/memory word width
// - RESET_PC    32'h0000_0000     byte address fetched first after reset
// - QUEUE_DEPTH 2                 instruction queue entries, >=2; 2 sustains 1 instr/cycle
//
// PORTS
// - i_clk          in   1           core clock
// - i_rst          in   1           synchronous reset, active-high
// - i_mem_data     in   DATA_WIDTH  BRAM port A read data; valid 1 cycle after o_mem_addr
// - o_mem_addr     out  32          BRAM word address = {2'b00, pc[31:2]}
// - o_mem_write    out  1           BRAM write enable; constant 0
// - o_inst         out  DATA_WIDTH  instruction at queue head
// - o_pc           out  32          byte address of o_inst
// - o_valid        out  1           o_inst/o_pc valid
// - i_ready        in   1           decode accepts; handshake = o_valid & i_ready
// - i_redirect     in   1           load new PC, flush
// - i_redirect_pc  in   32          redirect target (byte address)
//
// BEHAVIOUR
// - Reset (i_rst sampled high):
//   - pc=RESET_PC; queue empty; in-flight cleared.
//   - o_valid=0, o_inst=0, o_pc=0, o_mem_write=0.
//   - o_mem_addr=RESET_PC>>2.
// - Issue:
//   - A read of pc is issued in a cycle iff (queue_count + inflight - pop) < QUEUE_DEPTH.
//   - pop = handshake this cycle.
//   - On issue: pc <= pc+4; inflight <= 1.
//   - o_mem_addr always shows the current pc word address; an un-issued cycle re-presents the same address harmlessly.
// - Return: a word issued in cycle N is captured into the queue tail at the end of cycle N+1, tagged with its pc.
// - Latency:
//   - First cycle after reset release = cycle 0 (issue RESET_PC); o_valid=1 in cycle 2.
//   - With i_ready held 1: one instruction per cycle, no bubbles, PCs consecutive +4.
// - Backpressure:
//   - i_ready=0 holds o_inst/o_pc stable while o_valid=1.
//   - Issue stops when queue plus in-flight would overflow.
//   - No word is ever dropped or duplicated.
// - Queue: circular, wraps at QUEUE_DEPTH. Simultaneous push and pop at full or empty is legal; count unchanged.
// - Redirect (i_redirect=1 in cycle R):
//   - Queue flushed and in-flight read squashed (its return in R+1 is discarded).
//   - pc <= {i_redirect_pc[31:2],2'b00}; misaligned low bits are ignored.
//   - o_valid=0 in R+1 and R+2.
//   - Target issued in R+1, o_valid=1 in R+3 with o_pc=target.
//   - A handshake in cycle R completes normally (that instruction is consumed); all else is flushed.
//   - Back-to-back redirects: the last one wins.
// - Reset mid-operation overrides redirect and handshake; state returns to reset values next cycle.
// - PC arithmetic is modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.
//
// CONFIGURATION
// - FETCH_STATS_EN defined: adds two ports, both reset to 0, wrap at 2^32:
//   - o_fetch_count (out, 32): increments on each handshake.
//   - o_stall_count (out, 32): increments each cycle with o_valid=1 & i_ready=0.
// - FETCH_STATS_EN undefined: ports and counters are absent; behaviour is otherwise identical.
//
// TESTING
// - Reset release, i_ready=1, BRAM word k = 32'hA000_0000+k
//     -> o_valid rises in cycle 2; o_pc = 0,4,8,... every cycle; o_inst = A0000000, A0000001, ...
// - i_ready=0 for cycles 4..8, then 1
//     -> o_inst/o_pc frozen during the stall; sequence resumes with no gap or duplicate; o_mem_addr advances by at most QUEUE_DEPTH ahead.
// - i_redirect=1 with i_redirect_pc=32'h0000_0103 in cycle 6
//     -> o_valid=0 in cycles 7-8; cycle 9 o_pc=32'h100, o_inst=mem[0x40]; the squashed in-flight word never appears.
// - Redirect and handshake in the same cycle, then redirect again the next cycle
//     -> the handshaked instr counts once; only the second target's stream is delivered.
// - pc=32'hFFFF_FFF8 via redirect, i_ready=1
//     -> o_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
// - FETCH_STATS_EN: 10 handshakes plus 3 stall cycles, then i_rst
//     -> counters read 10/3 before reset, 0/0 after; o_mem_write=0 throughout.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, one BRAM read per cycle, small instruction queue, valid/ready to decode.
// Optional FETCH_STATS_EN adds handshake and stall counters.
module fetch_unit #(
  parameter int          DATA_WIDTH  = 32,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DATA_WIDTH-1:0] i_mem_data,
  output logic [31:0]           o_mem_addr,
  output logic                  o_mem_write,
  output logic [DATA_WIDTH-1:0] o_inst,
  output logic [31:0]           o_pc,
  output logic                  o_valid,
  input  logic                  i_ready,
  input  logic                  i_redirect,
  input  logic [31:0]           i_redirect_pc
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]           o_fetch_count,
  output logic [31:0]           o_stall_count
`endif
);

  localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(QUEUE_DEPTH - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  logic [31:0]           pc_q, pc_d;
  logic                  inflight_q, inflight_d;
  logic [31:0]           inflight_pc_q, inflight_pc_d;
  logic [PTR_W-1:0]      head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DATA_WIDTH-1:0] inst_q [QUEUE_DEPTH];
  logic [DATA_WIDTH-1:0] inst_d [QUEUE_DEPTH];
  logic [31:0]           tag_q  [QUEUE_DEPTH];
  logic [31:0]           tag_d  [QUEUE_DEPTH];

  logic                  pop, push, issue;
  logic [CNT_W:0]        occupancy;

  assign o_valid     = (count_q != '0);
  assign o_inst      = o_valid ? inst_q[head_q] : '0;
  assign o_pc        = o_valid ? tag_q[head_q] : '0;
  assign o_mem_addr  = pc_q >> 2;
  assign o_mem_write = 1'b0;

  assign pop       = o_valid & i_ready;
  assign push      = inflight_q;
  // Queue plus the outstanding read must still fit after this cycle's pop.
  assign occupancy = (CNT_W+1)'(count_q) + (CNT_W+1)'(inflight_q) - (CNT_W+1)'(pop);
  assign issue     = (occupancy < (CNT_W+1)'(QUEUE_DEPTH));

  always_comb begin
    pc_d          = pc_q;
    inflight_d    = inflight_q;
    inflight_pc_d = inflight_pc_q;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    inst_d        = inst_q;
    tag_d         = tag_q;
    if (i_redirect) begin
      // A read issued this cycle and the one returning now are both dropped.
      pc_d       = i_redirect_pc & 32'hFFFF_FFFC;
      inflight_d = 1'b0;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
    end else begin
      inflight_d = issue;
      if (issue) begin
        pc_d          = pc_q + 32'd4;
        inflight_pc_d = pc_q;
      end
      if (push) begin
        inst_d[tail_q] = i_mem_data;
        tag_d[tail_q]  = inflight_pc_q;
        tail_d         = ptr_inc(tail_q);
      end
      if (pop) head_d = ptr_inc(head_q);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pc_q       <= RESET_PC;
      inflight_q <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
    end else begin
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge i_clk) begin
    inflight_pc_q <= inflight_pc_d;
    inst_q        <= inst_d;
    tag_q         <= tag_d;
  end

`ifdef FETCH_STATS_EN
  logic [31:0] fetch_count_q, fetch_count_d;
  logic [31:0] stall_count_q, stall_count_d;

  always_comb begin
    fetch_count_d = fetch_count_q + {31'd0, pop};
    stall_count_d = stall_count_q + {31'd0, o_valid & ~i_ready};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      fetch_count_q <= '0;
      stall_count_q <= '0;
    end else begin
      fetch_count_q <= fetch_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign o_fetch_count = fetch_count_q;
  assign o_stall_count = stall_count_q;
`endif

endmodule
